msg_fifo: RTL and testbench

- Parametrised successor to the single-byte message register. Buffers up to DEPTH message words from the keypad/decoder path and drains them one at a time into the UART transmitter using the existing ready/transmit_ready handshake.
- Adds occupancy flags, an overflow flag, and optional line-buffered release.
- Sits between the message encoder (upstream, `ready`/`data`) and the UART TX (downstream, `tx_ctrl`/`tx_byte`/`transmit_ready`).

---
 rtl/msg_fifo.sv | 152 +++++++++++++++
 tb/tb_msg_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/msg_fifo.sv
// Message FIFO between the message encoder and the UART transmitter.
// Optional line-buffered release is enabled by defining MSG_EOL_EN.
module msg_fifo #(
  parameter int                 DATA_W   = 8,
  parameter int                 DEPTH    = 16,
  parameter logic [DATA_W-1:0]  EOL_CHAR = 8'h0A
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [DATA_W-1:0]          data,
  input  logic                       transmit_ready,
  input  logic                       clr_ovf,
  output logic                       tx_ctrl,
  output logic [DATA_W-1:0]          tx_byte,
  output logic                       blue,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_TRANSMIT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] tx_byte_reg;
  logic              overflow_reg;

  logic push, pop, drop, rel;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign tx_byte  = tx_byte_reg;
  assign overflow = overflow_reg;

  // A pop frees a slot in the same cycle, so a push at full is still accepted.
  assign push = ready && (!full || pop);
  assign drop = ready && full && !pop;

`ifdef MSG_EOL_EN
  logic [CNT_W-1:0] eol_cnt_reg;
  logic             draining_reg;
  logic             eol_inc, eol_dec;

  // The terminator count drops when the EOL word leaves through TRANSMIT,
  // which is before IDLE next looks at it.
  assign eol_inc = push && (data == EOL_CHAR);
  assign eol_dec = (state_reg == S_TRANSMIT) && (tx_byte_reg == EOL_CHAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eol_cnt_reg  <= '0;
      draining_reg <= 1'b0;
    end else begin
      case ({eol_inc, eol_dec})
        2'b10:   eol_cnt_reg <= eol_cnt_reg + CNT_W'(1);
        2'b01:   eol_cnt_reg <= eol_cnt_reg - CNT_W'(1);
        default: eol_cnt_reg <= eol_cnt_reg;
      endcase
      if (pop)
        draining_reg <= 1'b1;
      else if (state_reg == S_IDLE)
        draining_reg <= 1'b0;
    end
  end

  // Keep draining a started line until its terminator has gone out.
  assign rel = !empty && ((eol_cnt_reg != '0) || full ||
                          (draining_reg && (tx_byte_reg != EOL_CHAR)));
`else
  assign rel = !empty;
`endif

  always_comb begin
    state_next = state_reg;
    tx_ctrl    = 1'b0;
    blue       = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (rel) begin
          pop        = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        tx_ctrl = 1'b1;
        if (transmit_ready)
          state_next = S_TRANSMIT;
      end
      S_TRANSMIT: begin
        tx_ctrl    = 1'b1;
        blue       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Storage array carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_byte_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        tx_byte_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop)
        overflow_reg <= 1'b1;
      else if (clr_ovf)
        overflow_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msg_fifo.sv
// Directed self-checking bench for msg_fifo (default and MSG_EOL_EN builds).
module tb_msg_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              transmit_ready = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              tx_ctrl;
  logic [DATA_W-1:0] tx_byte;
  logic              blue;
  logic              full;
  logic              empty;
  logic [$clog2(DEPTH):0] count;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  msg_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .EOL_CHAR(8'h0A)) dut (
    .clk(clk), .rst(rst), .ready(ready), .data(data),
    .transmit_ready(transmit_ready), .clr_ovf(clr_ovf),
    .tx_ctrl(tx_ctrl), .tx_byte(tx_byte), .blue(blue),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run a fixed window, checking every blue pulse against exp_q in order.
  task automatic drain(input string tag, input int cycles);
    int pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      tick;
      if (blue) begin
        if (pulses < exp_q.size())
          chk(tag, {24'h0, tx_byte}, {24'h0, exp_q[pulses]});
        pulses++;
      end
    end
    chk({tag, "_pulses"}, pulses, exp_q.size());
  endtask

  task automatic do_reset;
    rst = 1'b1; ready = 1'b0; transmit_ready = 1'b0; clr_ovf = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    do_reset;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_empty", empty, 1);
      chk("idle_count", count, 0);
      chk("idle_tx_ctrl", tx_ctrl, 0);
      chk("idle_tx_byte", tx_byte, 8'h00);
      chk("idle_blue", blue, 0);
    end
    chk("idle_full", full, 0);
    chk("idle_overflow", overflow, 0);

`ifndef MSG_EOL_EN
    // Single word: pushed at edge 0, transmit_ready during cycle 5
    ready = 1'b1; data = 8'h41;
    tick;
    ready = 1'b0;
    chk("single_c1_tx_ctrl", tx_ctrl, 0);
    chk("single_c1_count", count, 1);
    tick;
    chk("single_c2_tx_ctrl", tx_ctrl, 1);
    chk("single_c2_tx_byte", tx_byte, 8'h41);
    chk("single_c2_count", count, 0);
    tick;
    tick;
    tick;
    chk("single_c5_blue", blue, 0);
    chk("single_c5_tx_ctrl", tx_ctrl, 1);
    transmit_ready = 1'b1;
    tick;
    transmit_ready = 1'b0;
    chk("single_c6_blue", blue, 1);
    chk("single_c6_tx_ctrl", tx_ctrl, 1);
    tick;
    chk("single_c7_tx_ctrl", tx_ctrl, 0);
    chk("single_c7_blue", blue, 0);
    chk("single_c7_count", count, 0);
    chk("single_c7_tx_byte_held", tx_byte, 8'h41);

    // Fill to full with transmit_ready low; the 18th word is dropped
    for (int i = 0; i < 18; i++) begin
      ready = 1'b1; data = 8'(i);
      tick;
      if (i == 16) begin
        chk("fill_count16", count, 16);
        chk("fill_full", full, 1);
        chk("fill_no_ovf_yet", overflow, 0);
      end
    end
    ready = 1'b0;
    chk("fill_overflow", overflow, 1);
    chk("fill_count_after_drop", count, 16);
    chk("fill_tx_ctrl", tx_ctrl, 1);
    chk("fill_hold_word", tx_byte, 8'h00);
    exp_q = {};
    for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
    transmit_ready = 1'b1;
    drain("fill_drain", 70);
    transmit_ready = 1'b0;
    chk("fill_drained_empty", empty, 1);
    chk("fill_drained_count", count, 0);
    chk("fill_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    // Push at full in the same cycle as the IDLE->WAIT pop
    for (int i = 0; i < 17; i++) begin
      ready = 1'b1; data = 8'h20 + 8'(i);
      tick;
    end
    ready = 1'b0;
    chk("simul_pre_count", count, 16);
    chk("simul_pre_tx_byte", tx_byte, 8'h20);
    transmit_ready = 1'b1;
    tick;
    chk("simul_transmit_blue", blue, 1);
    tick;
    chk("simul_idle_tx_ctrl", tx_ctrl, 0);
    chk("simul_idle_full", full, 1);
    ready = 1'b1; data = 8'hAA;
    tick;
    ready = 1'b0;
    chk("simul_count", count, 16);
    chk("simul_overflow", overflow, 0);
    chk("simul_tx_byte", tx_byte, 8'h21);
    exp_q = {};
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'h20 + 8'(i));
    exp_q.push_back(8'hAA);
    drain("simul_drain", 70);
    transmit_ready = 1'b0;
    chk("simul_empty", empty, 1);

    // Reset while in WAIT with three words stored
    for (int i = 0; i < 4; i++) begin
      ready = 1'b1; data = 8'h50 + 8'(i);
      tick;
    end
    ready = 1'b0;
    chk("rstmid_count", count, 3);
    chk("rstmid_tx_ctrl", tx_ctrl, 1);
    chk("rstmid_tx_byte", tx_byte, 8'h50);
    transmit_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rstmid_async_tx_ctrl", tx_ctrl, 0);
    tick;
    chk("rstmid_tx_ctrl_after", tx_ctrl, 0);
    chk("rstmid_count_after", count, 0);
    chk("rstmid_blue", blue, 0);
    chk("rstmid_tx_byte_after", tx_byte, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rstmid_post_blue", blue, 0);
      chk("rstmid_post_tx_ctrl", tx_ctrl, 0);
    end
    transmit_ready = 1'b0;
`else
    // Line-buffered: nothing leaves until the terminator arrives
    ready = 1'b1; data = 8'h48;
    tick;
    data = 8'h69;
    tick;
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("eol_hold_tx_ctrl", tx_ctrl, 0);
    end
    chk("eol_hold_count", count, 2);
    ready = 1'b1; data = 8'h0A;
    tick;
    ready = 1'b0;
    exp_q = {8'h48, 8'h69, 8'h0A};
    transmit_ready = 1'b1;
    drain("eol_drain", 30);
    transmit_ready = 1'b0;
    chk("eol_count_after", count, 0);
    chk("eol_tx_ctrl_after", tx_ctrl, 0);
    chk("eol_empty_after", empty, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
